sobel_stream: RTL and testbench

SOBEL_STREAM -- requirements
Module: sobel_stream

---
 rtl/sobel_pkg.sv | 27 ++
 rtl/sobel_line_buf.sv | 34 +++
 rtl/sobel_stream.sv | 222 ++++++++++++++++++++++
 tb/tb_sobel_stream.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  sobel_pkg
//  Shared mode encoding, control-state enum and gradient width helper.
//  Revision: 1.0
// ============================================================================
package sobel_pkg;

   localparam logic [1:0] c_mode_sum = 2'd0;
   localparam logic [1:0] c_mode_gx  = 2'd1;
   localparam logic [1:0] c_mode_gy  = 2'd2;
   localparam logic [1:0] c_mode_thr = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

   // Signed gradients of a 1,2,1 kernel difference need three extra bits.
   function automatic int grad_width(input int pix_width);
      return pix_width + 3;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_line_buf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  sobel_line_buf
//  One image line of storage: synchronous write, combinational read.
//  Revision: 1.0
// ============================================================================
module sobel_line_buf
   import sobel_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int WIDTH = 8,
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[addr] <= wr_data;
      end
   end

   // Read-before-write at the same address returns the previous line's pixel.
   assign rd_data = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/sobel_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  sobel_stream
//  Streaming 3x3 Sobel edge filter, two-stage pipeline with valid/ready.
//  Optional threshold mode compiled in with SOBEL_THRESH_EN.
//  Revision: 1.0
// ============================================================================
module sobel_stream
   import sobel_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int IMG_WIDTH  = 256,
   parameter int IMG_HEIGHT = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_sof,
   input  logic [1:0]       mode,
   input  logic [WIDTH+2:0] thresh,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_last,
   output logic             done,
   output logic             err
);

   localparam int GW = grad_width(WIDTH);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   localparam logic [CW-1:0] c_col_last = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] c_row_last = RW'(IMG_HEIGHT - 1);

   state_t          r_state;
   logic [CW-1:0]   r_col;
   logic [RW-1:0]   r_row;
   logic [1:0]      r_mode;
`ifdef SOBEL_THRESH_EN
   logic [GW-1:0]   r_thresh;
`else
   logic            w_unused_thresh;
   assign w_unused_thresh = ^thresh;
`endif

   logic            w_advance;
   logic            w_hs;
   logic            w_sof_hs;
   logic            w_acc;
   logic [CW-1:0]   w_addr;
   logic [WIDTH-1:0] w_lb0_rd;
   logic [WIDTH-1:0] w_lb1_rd;

   // Window: t/m/b = rows r-2, r-1, r; index 0 = column c-2, 1 = column c-1.
   logic [WIDTH-1:0] r_t0, r_t1, r_m0, r_m1, r_b0, r_b1;

   logic [GW-1:0]        w_xl, w_xr, w_yt, w_yb;
   logic signed [GW-1:0] w_gx, w_gy;

   logic                 r_s1_valid;
   logic                 r_s1_last;
   logic signed [GW-1:0] r_gx, r_gy;

   logic [GW-1:0]        w_ax, w_ay, w_sum, w_mag;
   logic [WIDTH-1:0]     w_pix;

   assign w_advance = !m_valid || m_ready;
   assign s_ready   = w_advance && (r_state != ST_DRAIN);
   assign w_hs      = s_valid && s_ready;
   assign w_sof_hs  = w_hs && s_sof;
   assign w_acc     = w_hs && ((r_state == ST_ACTIVE) || s_sof);
   assign w_addr    = w_sof_hs ? '0 : r_col;

   sobel_line_buf #(
      .DEPTH   (IMG_WIDTH),
      .WIDTH   (WIDTH)
   ) u_lb0 (
      .clk     (clk),
      .wr_en   (w_acc),
      .addr    (w_addr),
      .wr_data (s_data),
      .rd_data (w_lb0_rd)
   );

   sobel_line_buf #(
      .DEPTH   (IMG_WIDTH),
      .WIDTH   (WIDTH)
   ) u_lb1 (
      .clk     (clk),
      .wr_en   (w_acc),
      .addr    (w_addr),
      .wr_data (w_lb0_rd),
      .rd_data (w_lb1_rd)
   );

   function automatic logic [GW-1:0] wsum(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic [WIDTH-1:0] c);
      return GW'(a) + (GW'(b) << 1) + GW'(c);
   endfunction

   // Gradients use the window as it will look after this pixel shifts in.
   assign w_xl = wsum(r_t0, r_m0, r_b0);
   assign w_xr = wsum(w_lb1_rd, w_lb0_rd, s_data);
   assign w_yt = wsum(r_t0, r_t1, w_lb1_rd);
   assign w_yb = wsum(r_b0, r_b1, s_data);
   assign w_gx = $signed(w_xr - w_xl);
   assign w_gy = $signed(w_yb - w_yt);

   assign w_ax = r_gx[GW-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
   assign w_ay = r_gy[GW-1] ? $unsigned(-r_gy) : $unsigned(r_gy);

   always_comb begin
      w_sum = w_ax + w_ay;
      case (r_mode)
         c_mode_gx: w_mag = w_ax;
         c_mode_gy: w_mag = w_ay;
         default:   w_mag = w_sum;
      endcase
      w_pix = (|w_mag[GW-1:WIDTH]) ? '1 : w_mag[WIDTH-1:0];
`ifdef SOBEL_THRESH_EN
      if (r_mode == c_mode_thr) begin
         w_pix = (w_sum >= r_thresh) ? '1 : '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_t0 <= r_t1;
         r_t1 <= w_lb1_rd;
         r_m0 <= r_m1;
         r_m1 <= w_lb0_rd;
         r_b0 <= r_b1;
         r_b1 <= s_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_col      <= '0;
         r_row      <= '0;
         r_mode     <= c_mode_sum;
`ifdef SOBEL_THRESH_EN
         r_thresh   <= '0;
`endif
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_gx       <= '0;
         r_gy       <= '0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         m_last     <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;

         if (w_sof_hs) begin
            r_mode   <= mode;
`ifdef SOBEL_THRESH_EN
            r_thresh <= thresh;
`endif
         end

         case (r_state)
            ST_IDLE: begin
               if (w_sof_hs) begin
                  r_state <= ST_ACTIVE;
                  r_col   <= CW'(1);
                  r_row   <= '0;
               end
            end
            ST_ACTIVE: begin
               if (w_sof_hs) begin
                  err   <= 1'b1;
                  r_col <= CW'(1);
                  r_row <= '0;
               end else if (w_hs) begin
                  if (r_col == c_col_last) begin
                     r_col <= '0;
                     if (r_row == c_row_last) begin
                        r_row   <= '0;
                        r_state <= ST_DRAIN;
                     end else begin
                        r_row <= r_row + 1'b1;
                     end
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               if (m_valid && m_ready && m_last) begin
                  r_state <= ST_IDLE;
                  done    <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         // A new frame start flushes whatever the pipeline still holds.
         if (w_advance) begin
            r_s1_valid <= w_acc && !w_sof_hs && (r_row >= RW'(2)) && (r_col >= CW'(2));
            r_s1_last  <= (r_row == c_row_last) && (r_col == c_col_last);
            r_gx       <= w_gx;
            r_gy       <= w_gy;
            m_valid    <= r_s1_valid && !w_sof_hs;
            m_last     <= r_s1_valid && r_s1_last && !w_sof_hs;
            m_data     <= w_pix;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  tb_sobel_stream
//  Randomised and directed frames checked against an image-level Sobel model.
//  Revision: 1.0
// ============================================================================
module tb_sobel_stream;

   localparam int W  = 8;
   localparam int IW = 8;
   localparam int IH = 6;
   localparam int GW = W + 3;
   localparam int NOUT = (IW - 2) * (IH - 2);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [W-1:0]  s_data = '0;
   logic          s_sof = 1'b0;
   logic [1:0]    mode = 2'd0;
   logic [GW-1:0] thresh = '0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [W-1:0]  m_data;
   logic          m_last;
   logic          done;
   logic          err;

   sobel_stream #(
      .WIDTH      (W),
      .IMG_WIDTH  (IW),
      .IMG_HEIGHT (IH)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .s_sof   (s_sof),
      .mode    (mode),
      .thresh  (thresh),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_data  (m_data),
      .m_last  (m_last),
      .done    (done),
      .err     (err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;
   int img [IH][IW];
   int exp_q [$];
   int got_q [$];
   int rdy_pat = 0;

   int last_cnt = 0, last_pos = 0, last_cyc = 0;
   int done_cnt = 0, done_cyc = 0;
   int err_cnt = 0, err_pos = 0;
   int stall_viol = 0, hold_viol = 0, cyc = 0;
   logic         prev_stall = 1'b0;
   logic [W-1:0] prev_data = '0;
   logic         prev_last = 1'b0;

   // Negedge observer: inputs are stable here, so a visible valid&&ready
   // is exactly the handshake that the next rising edge performs.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
         hold_viol <= hold_viol + 1;
      if (m_valid && !m_ready && s_ready)
         stall_viol <= stall_viol + 1;
      if (m_valid && m_ready) begin
         got_q.push_back(int'(m_data));
         if (m_last) begin
            last_cnt <= last_cnt + 1;
            last_pos <= got_q.size() - 1;
            last_cyc <= cyc;
         end
      end
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      if (err) begin
         err_cnt <= err_cnt + 1;
         err_pos <= got_q.size();
      end
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_last  <= m_last;
   end

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      case (rdy_pat)
         0:       m_ready = 1'b1;
         1:       m_ready = ~m_ready;
         default: m_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic push(input int d, input bit sof);
      bit a;
      bit ok = 1'b0;
      s_valid = 1'b1;
      s_data  = W'(d);
      s_sof   = sof;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         a = s_ready;
         tick();
         if (a) begin
            ok = 1'b1;
            break;
         end
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
      if (!ok) check("push_timeout", 0, 1);
   endtask

   // Image-level Sobel reference for the output centred at (y,x).
   function automatic int ref_pix(int y, int x, int md, int th);
      int gx = 0, gy = 0, ax, ay, m, wt;
      for (int i = 0; i < 3; i++) begin
         wt = (i == 1) ? 2 : 1;
         gx += wt * (img[y-1+i][x+1] - img[y-1+i][x-1]);
         gy += wt * (img[y+1][x-1+i] - img[y-1][x-1+i]);
      end
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      case (md)
         1:       m = ax;
         2:       m = ay;
`ifdef SOBEL_THRESH_EN
         3:       return (ax + ay >= th) ? 255 : 0;
`endif
         default: m = ax + ay;
      endcase
      return (m > 255) ? 255 : m;
   endfunction

   task automatic build_exp(input int md, input int th);
      exp_q.delete();
      for (int y = 1; y < IH - 1; y++)
         for (int x = 1; x < IW - 1; x++)
            exp_q.push_back(ref_pix(y, x, md, th));
   endtask

   task automatic fill_rand(input int maxv);
      for (int y = 0; y < IH; y++)
         for (int x = 0; x < IW; x++)
            img[y][x] = $urandom_range(0, maxv);
   endtask

   task automatic wait_done(input string tag, input int b_done);
      for (int i = 0; i < 400 && done_cnt == b_done; i++) tick();
      check({tag, "_done_seen"}, done_cnt - b_done, 1);
      repeat (3) tick();
   endtask

   task automatic check_outs(input string tag, input int base);
      check({tag, "_n_out"}, got_q.size() - base, NOUT);
      for (int i = 0; i < NOUT; i++)
         if (base + i < got_q.size())
            check($sformatf("%s_px%0d", tag, i), got_q[base + i], exp_q[i]);
   endtask

   task automatic run_frame(input string tag, input int md, input int th, input int pat);
      int b_got, b_last, b_done, b_err, b_hold, b_stall;
      mode    = 2'(md);
      thresh  = GW'(th);
      rdy_pat = pat;
      build_exp(md, th);
      b_got = got_q.size(); b_last = last_cnt; b_done = done_cnt;
      b_err = err_cnt; b_hold = hold_viol; b_stall = stall_viol;
      for (int y = 0; y < IH; y++)
         for (int x = 0; x < IW; x++)
            push(img[y][x], (y == 0) && (x == 0));
      wait_done(tag, b_done);
      check_outs(tag, b_got);
      check({tag, "_last_cnt"}, last_cnt - b_last, 1);
      check({tag, "_last_pos"}, last_pos - b_got, NOUT - 1);
      check({tag, "_done_lat"}, done_cyc - last_cyc, 1);
      check({tag, "_err_cnt"}, err_cnt - b_err, 0);
      check({tag, "_hold"}, hold_viol - b_hold, 0);
      check({tag, "_stall_rdy"}, stall_viol - b_stall, 0);
      rdy_pat = 0;
      tick();
   endtask

   initial begin
      int b_got, b_last, b_done, b_err;

      // Reset state
      repeat (3) tick();
      check("rst_m_valid", int'(m_valid), 0);
      check("rst_m_data",  int'(m_data), 0);
      check("rst_m_last",  int'(m_last), 0);
      check("rst_done",    int'(done), 0);
      check("rst_err",     int'(err), 0);
      check("rst_s_ready", int'(s_ready), 1);
      rst_n = 1'b1;
      repeat (2) tick();

      // Flat frame
      for (int y = 0; y < IH; y++) for (int x = 0; x < IW; x++) img[y][x] = 100;
      run_frame("flat", 0, 0, 0);

      // Vertical step edge
      for (int y = 0; y < IH; y++) for (int x = 0; x < IW; x++) img[y][x] = (x < 4) ? 0 : 200;
      run_frame("step_m0", 0, 0, 0);
      run_frame("step_m2", 2, 0, 0);
      run_frame("step_m0_tog", 0, 0, 1);

      // Horizontal ramp, threshold mode
      for (int y = 0; y < IH; y++) for (int x = 0; x < IW; x++) img[y][x] = 10 * x;
      run_frame("ramp_t100", 3, 100, 0);
      run_frame("ramp_t80", 3, 80, 0);

      // Random frames, preceded by non-sof pixels that IDLE must discard
      for (int f = 0; f < 4; f++) begin
         for (int k = 0; k < 5; k++) push($urandom_range(0, 255), 1'b0);
         fill_rand((f % 2 == 0) ? 255 : 40);
         run_frame($sformatf("rand%0d", f), $urandom_range(0, 3), $urandom_range(0, 600), 2);
      end

      // Aborted frame A followed by flat frame B
      fill_rand(255);
      mode = 2'd0;
      for (int i = 0; i < 20; i++) push(img[i / IW][i % IW], i == 0);
      for (int y = 0; y < IH; y++) for (int x = 0; x < IW; x++) img[y][x] = 100;
      build_exp(0, 0);
      b_last = last_cnt; b_done = done_cnt; b_err = err_cnt;
      for (int y = 0; y < IH; y++)
         for (int x = 0; x < IW; x++)
            push(img[y][x], (y == 0) && (x == 0));
      wait_done("abort", b_done);
      check("abort_err_cnt", err_cnt - b_err, 1);
      check_outs("abort", err_pos);
      check("abort_last_cnt", last_cnt - b_last, 1);
      check("abort_done_cnt", done_cnt - b_done, 1);

      // Reset in the middle of a frame
      fill_rand(255);
      mode = 2'd0;
      for (int i = 0; i < 25; i++) push(img[i / IW][i % IW], i == 0);
      rst_n = 1'b0;
      #1;
      check("midrst_m_valid", int'(m_valid), 0);
      b_got = got_q.size();
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      check("midrst_no_out", got_q.size() - b_got, 0);
      fill_rand(255);
      run_frame("after_rst", 1, 0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
